// File: rtl/mult16_pkg.sv
// Shared widths and FSM state encoding for the mult16 streaming multiplier.
package mult16_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int PSUM_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mult16_core.sv
// Purely combinational 16x16 unsigned multiplier; also exposes the two
// partial sums (multiplier rows 0-7 and 8-15) for the split-pipeline build.
module mult16_core
  import mult16_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product,
  output logic [PSUM_W-1:0] psum_lo,
  output logic [PSUM_W-1:0] psum_hi
);

  assign product = PROD_W'(a) * PROD_W'(b);
  assign psum_lo = PSUM_W'(a) * PSUM_W'(b[7:0]);
  assign psum_hi = PSUM_W'(a) * PSUM_W'(b[15:8]);

endmodule

// File: rtl/mult16_stream.sv
// Valid/ready streaming multiplier with frame tracking and delivery counters.
// Define MULT16_PIPE2_EN to add the S1b partial-sum register stage.
module mult16_stream
  import mult16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_last,
  output logic [CNT_W-1:0]  prod_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy
);

  state_t state, state_nx;

  logic            en;
  logic            s1_full, s1_last;
  logic [OP_W-1:0] s1_a, s1_b;
  logic            accept, deliver, s1_adv, feed_adv;
  logic            feed_full, feed_last;
  logic [PROD_W-1:0] feed_p;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // S2 loads whenever it is empty or being emptied this cycle
  assign feed_adv = feed_full && (!out_valid || deliver);

`ifdef MULT16_PIPE2_EN
  logic              s1b_full, s1b_last;
  logic [PSUM_W-1:0] s1b_lo, s1b_hi, ps_lo, ps_hi;

  mult16_core u_core (
    .a       (s1_a),
    .b       (s1_b),
    .product (),
    .psum_lo (ps_lo),
    .psum_hi (ps_hi)
  );

  assign s1_adv    = s1_full && (!s1b_full || feed_adv);
  assign feed_full = s1b_full;
  assign feed_last = s1b_last;
  assign feed_p    = {8'b0, s1b_lo} + {s1b_hi, 8'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1b_full <= 1'b0;
      s1b_last <= 1'b0;
      s1b_lo   <= '0;
      s1b_hi   <= '0;
    end else if (s1_adv) begin
      s1b_full <= 1'b1;
      s1b_last <= s1_last;
      s1b_lo   <= ps_lo;
      s1b_hi   <= ps_hi;
    end else if (feed_adv) begin
      s1b_full <= 1'b0;
    end
  end
`else
  logic [PROD_W-1:0] mul_p;

  mult16_core u_core (
    .a       (s1_a),
    .b       (s1_b),
    .product (mul_p),
    .psum_lo (),
    .psum_hi ()
  );

  assign s1_adv    = feed_adv;
  assign feed_full = s1_full;
  assign feed_last = s1_last;
  assign feed_p    = mul_p;
`endif

  // en holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      state   <= IDLE;
      s1_full <= 1'b0;
      s1_last <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
    end else begin
      en    <= 1'b1;
      state <= state_nx;
      if (accept) begin
        s1_full <= 1'b1;
        s1_last <= in_last;
        s1_a    <= in_a;
        s1_b    <= in_b;
      end else if (s1_adv) begin
        s1_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_last    <= 1'b0;
      prod_cnt    <= '0;
      frame_cnt   <= '0;
    end else begin
      if (feed_adv) begin
        out_valid   <= 1'b1;
        out_product <= feed_p;
        out_last    <= feed_last;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
      if (deliver) begin
        prod_cnt <= prod_cnt + CNT_W'(1);
        if (out_last) frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    in_ready = en && (state != DRAIN) && (!s1_full || s1_adv);
    case (state)
      IDLE:    if (accept) state_nx = in_last ? DRAIN : ACTIVE;
      ACTIVE:  if (accept && in_last) state_nx = DRAIN;
      DRAIN:   if (deliver && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult16_stream.sv
// Directed bench for mult16_stream: scoreboarded products, frame drain,
// mid-stream reset and a narrow-counter instance for wrap-around.
module tb_mult16_stream;

`ifdef MULT16_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_product;
  logic [15:0] prod_cnt, frame_cnt;

  logic        n_in_ready, n_out_valid, n_out_last, n_busy;
  logic [31:0] n_out_product;
  logic [3:0]  n_prod_cnt, n_frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int deliveries = 0;

  logic [32:0] exp_q[$];
  logic [32:0] cur_exp;
  logic [32:0] held;
  logic        hold_pend = 1'b0;
  logic        rand_rdy = 1'b0;

  always #5 clk = ~clk;

  mult16_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .out_last(out_last),
    .prod_cnt(prod_cnt), .frame_cnt(frame_cnt), .busy(busy)
  );

  mult16_stream #(.CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_product(n_out_product), .out_last(n_out_last),
    .prod_cnt(n_prod_cnt), .frame_cnt(n_frame_cnt), .busy(n_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, score deliveries, then step past the edge.
  task automatic cycle(output bit acc);
    logic [32:0] e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (hold_pend) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_product", out_product, held[31:0]);
      chk("hold_last", 32'(out_last), 32'(held[32]));
    end
    hold_pend = out_valid && !out_ready;
    held = {out_last, out_product};
    if (out_valid && out_ready) begin
      deliveries++;
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("product", out_product, e[31:0]);
        chk("out_last", 32'(out_last), 32'(e[32]));
      end
    end
    if (acc) exp_q.push_back(cur_exp);
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic [31:0] exp, output int waits);
    bit acc;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    cur_exp = {last, exp};
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 200) begin
      cycle(acc);
      if (!acc) waits++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle(acc);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_prod_cnt", 32'(prod_cnt), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d0;
    bit acc;
    logic [15:0] f0;
    logic [15:0] ra, rb;
    in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    do_reset();

    // single pair
    send(16'h1234, 16'h5678, 1'b1, 32'h06260060, w);
    in_valid = 1'b0;
    chk("single_wait", 32'(w), 0);
    for (int i = 0; i < LAT; i++) begin
      chk("single_lat_empty", 32'(out_valid), 0);
      cycle(acc);
    end
    chk("single_valid", 32'(out_valid), 1);
    chk("single_prod", out_product, 32'h06260060);
    chk("single_last", 32'(out_last), 1);
    chk("single_drain_rdy", 32'(in_ready), 0);
    chk("single_busy", 32'(busy), 1);
    cycle(acc);
    chk("single_frame_cnt", 32'(frame_cnt), 1);
    chk("single_prod_cnt", 32'(prod_cnt), 1);
    chk("single_idle", 32'(busy), 0);

    // corners, back to back
    send(16'h0000, 16'hFFFF, 1'b0, 32'h00000000, w);
    send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, w);
    chk("corner_thru1", 32'(w), 0);
    send(16'h0001, 16'h8000, 1'b1, 32'h00008000, w);
    chk("corner_thru2", 32'(w), 0);
    drain();
    chk("corner_prod_cnt", 32'(prod_cnt), 4);

    // frame drain with in_valid held high
    f0 = frame_cnt;
    send(16'd11, 16'd22, 1'b0, 32'd242, w);
    send(16'd33, 16'd44, 1'b0, 32'd1452, w);
    send(16'd55, 16'd66, 1'b1, 32'd3630, w);
    chk("drain_in_ready", 32'(in_ready), 0);
    send(16'd77, 16'd88, 1'b1, 32'd6776, w);
    chk("drain_stall", 32'(w), 32'(LAT + 1));
    chk("drain_frame_cnt", 32'(frame_cnt), 32'(f0 + 16'd1));
    drain();
    chk("drain_frame_cnt2", 32'(frame_cnt), 32'(f0 + 16'd2));

    // reset with two pairs in flight
    out_ready = 1'b0;
    send(16'd100, 16'd200, 1'b0, 32'd20000, w);
    send(16'd300, 16'd400, 1'b0, 32'd120000, w);
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    do_reset();
    out_ready = 1'b1;
    d0 = deliveries;
    repeat (6) cycle(acc);
    chk("no_stale", 32'(deliveries - d0), 0);
    chk("no_stale_valid", 32'(out_valid), 0);

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++)
      send(16'(i + 1), 16'd3, 1'(i == 16), 32'((i + 1) * 3), w);
    drain();
    chk("wrap_narrow_prod", 32'(n_prod_cnt), 1);
    chk("wrap_narrow_frame", 32'(n_frame_cnt), 1);
    chk("wrap_wide_prod", 32'(prod_cnt), 17);

    // random pairs under random backpressure
    do_reset();
    d0 = deliveries;
    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send(ra, rb, 1'(i == 63), 32'(ra) * 32'(rb), w);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    chk("bp_prod_cnt", 32'(prod_cnt), 64);
    chk("bp_deliveries", 32'(deliveries - d0), 64);
    chk("bp_frame_cnt", 32'(frame_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult16_stream.md
MULT16_STREAM -- requirements
Module: mult16_stream

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the product and frame counters.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-006 SHALL have port in_a, in_b  input  16 each  unsigned operands.
REQ-007 SHALL have port in_last  input  1  marks the final pair of a frame.
REQ-008 SHALL have port out_valid  output  1  product present.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port out_product  output  32  unsigned product in_a*in_b.
REQ-011 SHALL have port out_last  output  1  in_last carried alongside the product.
REQ-012 SHALL have ports prod_cnt, frame_cnt  output  CNT_W each  count of delivered products and of delivered frames.
REQ-013 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-014 SHALL accept a pair when in_valid && in_ready, and deliver a product when out_valid && out_ready.
REQ-015 SHALL register operands in stage S1, compute the product combinationally from S1, and register it in output stage S2; latency is 1 cycle from acceptance to out_valid (2 cycles with MULT16_PIPE2_EN).
REQ-016 SHALL sustain one accepted pair per cycle while out_ready stays high.
REQ-017 SHALL drive in_ready = !S1_full || (S2 advances this cycle); a stage advances when its successor is empty or its successor is being emptied in the same cycle.
REQ-018 SHALL hold out_product and out_last stable while out_valid && !out_ready.
REQ-019 SHALL never drop or duplicate a pair under any valid/ready pattern, including simultaneous accept and deliver when all stages are full.
REQ-020 SHALL produce the exact 32-bit product with no truncation; 0xFFFF*0xFFFF = 0xFFFE0001.
REQ-021 SHALL implement FSM states IDLE, ACTIVE, and DRAIN.
REQ-022 SHALL transition IDLE->ACTIVE when a pair is accepted, and ACTIVE->DRAIN when a pair with in_last=1 is accepted.
REQ-023 SHALL keep in_ready low in DRAIN, and transition DRAIN->IDLE when the product with out_last=1 is delivered.
REQ-024 SHALL take a pair accepted in IDLE with in_last=1 straight to DRAIN.
REQ-025 SHALL increment prod_cnt on every delivery and frame_cnt on every delivery with out_last=1; both wrap modulo 2^CNT_W without saturation.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: all stages empty, FSM=IDLE, out_valid=0, out_product=0, out_last=0, prod_cnt=0, frame_cnt=0, busy=0, in_ready=0.
REQ-027 SHALL discard in-flight pairs on reset mid-operation, with no product emitted for them.
REQ-028 SHALL raise in_ready on the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when MULT16_PIPE2_EN is defined, insert a register stage S1b between the multiply and S2, splitting the 32-bit partial-product reduction (rows 0-7 and rows 8-15 summed separately, then added in S2); latency becomes 2 and full throughput is kept.
REQ-030 SHALL, when MULT16_PIPE2_EN is undefined, have latency 1, no S1b, and a single combinational multiply.
REQ-031 SHALL have the DRAIN exit condition and the counters behave identically in both builds.

Structure
REQ-032 SHALL place the FSM state typedef (IDLE/ACTIVE/DRAIN), the operand width 16 and the product width 32 in the shared package mult16_pkg.
REQ-033 SHALL instantiate the multiply as the purely combinational sub-module mult16_core (16x16 unsigned, 32-bit out); all sequential logic stays in mult16_stream.

Verification
REQ-034 Single pair: a=0x1234, b=0x5678, in_last=1, out_ready=1 -> out_product=0x06260060 one cycle after accept (two with PIPE2), out_last=1, frame_cnt=1, FSM back in IDLE.
REQ-035 Corners: pairs (0,0xFFFF), (0xFFFF,0xFFFF), (1,0x8000) -> products 0, 0xFFFE0001, 0x00008000, in order.
REQ-036 Backpressure: 64 random pairs with random out_ready (50%) -> products match the reference model in order, none lost, prod_cnt=64.
REQ-037 Frame drain: in_last on pair 3 with in_valid held high -> in_ready=0 until the third product is delivered, then next frame accepted; frame_cnt increments by 1.
REQ-038 Reset mid-stream: assert rst_n low with 2 pairs in flight -> out_valid=0 immediately, counters 0, no stale product after release.
REQ-039 Wrap: CNT_W=4, 17 deliveries -> prod_cnt=1.
